// File: rtl/edge_spike_injector.sv
// edge_spike_injector
// Off-grid transmitter that feeds host-generated spike packets into the west
// (or any) edge of the core mesh, looking to the core like a neighbouring
// router output buffer (dout / empty_out / ren_in).
//
// The host fills a FIFO with {eof, packet} entries grouped into EOF-marked
// frames. On each tick, if at least one complete frame is buffered, exactly
// one frame is streamed out; the stream stops after the EOF entry is popped
// and the rest waits for the next tick.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   tick                 global tick pulse
//   wr_valid/wr_packet/wr_eof/wr_ready   host write side
//   dout/empty_out/ren_in                mesh-facing FWFT read side
//   frame_active/frame_done/frame_count  frame status
//   fill_level           FIFO occupancy 0..DEPTH
//   overflow_error/underflow_error       sticky error flags
module edge_spike_injector #(
    parameter int PACKET_WIDTH = 30,
    parameter int DEPTH        = 64,
    parameter int ADDR_WIDTH   = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    wr_valid,
    input  logic [PACKET_WIDTH-1:0] wr_packet,
    input  logic                    wr_eof,
    output logic                    wr_ready,
    output logic [PACKET_WIDTH-1:0] dout,
    output logic                    empty_out,
    input  logic                    ren_in,
    output logic                    frame_active,
    output logic                    frame_done,
    output logic [ADDR_WIDTH:0]     frame_count,
    output logic [ADDR_WIDTH:0]     fill_level,
    output logic                    overflow_error,
    output logic                    underflow_error
);

    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE        = (ADDR_WIDTH+1)'(1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t state, state_next;

    // Entry layout: bit PACKET_WIDTH is the EOF marker.
    logic [PACKET_WIDTH:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic                    fifo_empty;
    logic                    head_eof;
    logic                    wr_accept;
    logic                    pop;

    assign fifo_empty = (fill_level == '0);
    assign head_eof   = mem[rd_ptr][PACKET_WIDTH];
    // wr_ready comes from the registered fill, so a pop while full only
    // frees the slot for the next cycle.
    assign wr_ready   = (fill_level != FULL_LEVEL);
    assign wr_accept  = wr_valid && wr_ready;
    assign pop        = ren_in && !empty_out;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            // frame_count here is the registered value, so an EOF written in
            // the same cycle as the tick does not start a frame.
            IDLE:   if (tick && frame_count != '0) state_next = STREAM;
            STREAM: if (pop && head_eof)           state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        frame_active = 1'b0;
        empty_out    = 1'b1;
        dout         = '0;
        if (state == STREAM) begin
            frame_active = 1'b1;
            empty_out    = fifo_empty;
            if (!fifo_empty) dout = mem[rd_ptr][PACKET_WIDTH-1:0];
        end
    end

    // ---------------- FIFO storage ----------------
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr] <= {wr_eof, wr_packet};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fill_level      <= '0;
            frame_count     <= '0;
            frame_done      <= 1'b0;
            overflow_error  <= 1'b0;
            underflow_error <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;

            case ({wr_accept, pop})
                2'b10:   fill_level <= fill_level + ONE;
                2'b01:   fill_level <= fill_level - ONE;
                default: fill_level <= fill_level;
            endcase

            case ({wr_accept && wr_eof, pop && head_eof})
                2'b10:   frame_count <= frame_count + ONE;
                2'b01:   frame_count <= frame_count - ONE;
                default: frame_count <= frame_count;
            endcase

            frame_done <= pop && head_eof;

            if (wr_valid && !wr_ready) overflow_error  <= 1'b1;
            if (ren_in && empty_out)   underflow_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_edge_spike_injector.sv
// Directed bench for edge_spike_injector. A queue-based model of the
// injector is checked against the DUT on every cycle, and the directed
// sequences add hand-computed literal expectations.
module tb_edge_spike_injector;

    localparam int PW    = 30;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          wr_valid = 1'b0;
    logic [PW-1:0] wr_packet = '0;
    logic          wr_eof = 1'b0;
    logic          wr_ready;
    logic [PW-1:0] dout;
    logic          empty_out;
    logic          ren_in = 1'b0;
    logic          frame_active;
    logic          frame_done;
    logic [AW:0]   frame_count;
    logic [AW:0]   fill_level;
    logic          overflow_error;
    logic          underflow_error;

    edge_spike_injector #(.PACKET_WIDTH(PW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .wr_valid(wr_valid), .wr_packet(wr_packet), .wr_eof(wr_eof), .wr_ready(wr_ready),
        .dout(dout), .empty_out(empty_out), .ren_in(ren_in),
        .frame_active(frame_active), .frame_done(frame_done),
        .frame_count(frame_count), .fill_level(fill_level),
        .overflow_error(overflow_error), .underflow_error(underflow_error)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- model ----------------
    // Queue holds {eof, packet}; streaming is a single bit.
    logic [PW:0] q[$];
    bit m_stream = 0, m_done = 0, m_of = 0, m_uf = 0;

    function automatic int eof_count();
        int c = 0;
        foreach (q[i]) if (q[i][PW]) c++;
        return c;
    endfunction

    function automatic bit m_empty();
        return !m_stream || q.size() == 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_stream = 0; m_done = 0; m_of = 0; m_uf = 0;
        end else begin
            bit emp, pop, acc, start, heof;
            emp   = m_empty();
            pop   = ren_in && !emp;
            heof  = pop && q[0][PW];
            acc   = wr_valid && q.size() < DEPTH;
            start = !m_stream && tick && eof_count() > 0;
            if (ren_in && emp) m_uf = 1;
            if (wr_valid && !acc) m_of = 1;
            m_done = heof;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back({wr_eof, wr_packet});
            if (start) m_stream = 1;
            else if (heof) m_stream = 0;
        end
    end

    // Outputs are register-driven only, so the falling edge is a safe
    // sampling point for both DUT and model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("empty_out",    32'(empty_out),    32'(m_empty()));
            chk("dout",         32'(dout),         m_empty() ? 32'h0 : 32'(q[0][PW-1:0]));
            chk("wr_ready",     32'(wr_ready),     32'(q.size() < DEPTH));
            chk("frame_active", 32'(frame_active), 32'(m_stream));
            chk("frame_done",   32'(frame_done),   32'(m_done));
            chk("frame_count",  32'(frame_count),  32'(eof_count()));
            chk("fill_level",   32'(fill_level),   32'(q.size()));
            chk("overflow",     32'(overflow_error),  32'(m_of));
            chk("underflow",    32'(underflow_error), 32'(m_uf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [PW-1:0] p, input logic e);
        wr_valid = 1'b1; wr_packet = p; wr_eof = e;
        @(negedge clk);
        wr_valid = 1'b0; wr_eof = 1'b0; wr_packet = '0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;
        // reset state
        chk("rst_empty", 32'(empty_out), 32'd1);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_fill", 32'(fill_level), 32'd0);

        // 1) basic three-packet frame
        wr(30'h101, 1'b0); wr(30'h102, 1'b0); wr(30'h103, 1'b1);
        chk("t1_fc", 32'(frame_count), 32'd1);
        chk("t1_fill", 32'(fill_level), 32'd3);
        chk("t1_idle_empty", 32'(empty_out), 32'd1);
        do_tick();
        ren_in = 1'b1;
        chk("t1_empty_after_tick", 32'(empty_out), 32'd0);
        chk("t1_dout0", 32'(dout), 32'h101);
        @(negedge clk); chk("t1_dout1", 32'(dout), 32'h102);
        @(negedge clk); chk("t1_dout2", 32'(dout), 32'h103);
        @(negedge clk); ren_in = 1'b0;
        chk("t1_done", 32'(frame_done), 32'd1);
        chk("t1_fc_end", 32'(frame_count), 32'd0);
        chk("t1_active_end", 32'(frame_active), 32'd0);
        @(negedge clk); chk("t1_done_pulse", 32'(frame_done), 32'd0);

        // 2) two frames, one tick releases only the first
        wr(30'h201, 1'b0); wr(30'h202, 1'b1); wr(30'h301, 1'b1);
        chk("t2_fc", 32'(frame_count), 32'd2);
        do_tick();
        ren_in = 1'b1;
        chk("t2_dout0", 32'(dout), 32'h201);
        @(negedge clk); chk("t2_dout1", 32'(dout), 32'h202);
        @(negedge clk); ren_in = 1'b0;
        chk("t2_held_empty", 32'(empty_out), 32'd1);
        chk("t2_held_fill", 32'(fill_level), 32'd1);
        repeat (3) @(negedge clk);
        chk("t2_still_empty", 32'(empty_out), 32'd1);
        do_tick();
        chk("t2_second_frame", 32'(dout), 32'h301);
        ren_in = 1'b1;
        @(negedge clk); ren_in = 1'b0;
        chk("t2_fc_end", 32'(frame_count), 32'd0);

        // 3) fill to DEPTH (pointers start mid-array, so they wrap), overflow
        for (int i = 0; i < DEPTH; i++) wr(PW'(32'h1000 + i), i == DEPTH - 1);
        chk("t3_full_fill", 32'(fill_level), 32'd64);
        chk("t3_wr_ready", 32'(wr_ready), 32'd0);
        wr(30'hAAA, 1'b1);
        chk("t3_overflow", 32'(overflow_error), 32'd1);
        chk("t3_fill_held", 32'(fill_level), 32'd64);
        chk("t3_fc_held", 32'(frame_count), 32'd1);
        do_tick();
        ren_in = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3_drain", 32'(dout), 32'h1000 + i);
            @(negedge clk);
        end
        ren_in = 1'b0;
        chk("t3_drain_done", 32'(frame_done), 32'd1);
        chk("t3_drain_fill", 32'(fill_level), 32'd0);
        chk("t3_no_underflow", 32'(underflow_error), 32'd0);

        // 4) underflow: nothing buffered, then data buffered but not ticked
        do_reset();
        chk("t4_of_cleared", 32'(overflow_error), 32'd0);
        ren_in = 1'b1; @(negedge clk); ren_in = 1'b0;
        chk("t4_uf_empty", 32'(underflow_error), 32'd1);
        do_reset();
        wr(30'h401, 1'b1);
        ren_in = 1'b1; @(negedge clk); ren_in = 1'b0;
        chk("t4_uf_idle", 32'(underflow_error), 32'd1);
        chk("t4_no_pop", 32'(fill_level), 32'd1);

        // 5) reset mid-stream flushes
        do_reset();
        wr(30'h501, 1'b0); wr(30'h502, 1'b0); wr(30'h503, 1'b1);
        do_tick();
        ren_in = 1'b1; @(negedge clk); ren_in = 1'b0;
        chk("t5_mid_dout", 32'(dout), 32'h502);
        do_reset();
        chk("t5_fill", 32'(fill_level), 32'd0);
        chk("t5_fc", 32'(frame_count), 32'd0);
        chk("t5_empty", 32'(empty_out), 32'd1);
        do_tick();
        chk("t5_tick_nothing", 32'(empty_out), 32'd1);
        chk("t5_active", 32'(frame_active), 32'd0);

        // 6) same-cycle eof write and eof pop
        wr(30'h601, 1'b1);
        do_tick();
        chk("t6_dout", 32'(dout), 32'h601);
        ren_in = 1'b1;
        wr(30'h602, 1'b1);
        ren_in = 1'b0;
        chk("t6_fc", 32'(frame_count), 32'd1);
        chk("t6_fill", 32'(fill_level), 32'd1);
        chk("t6_done", 32'(frame_done), 32'd1);
        // same-cycle tick and first EOF write does not start a frame
        do_reset();
        tick = 1'b1; wr(30'h701, 1'b1); tick = 1'b0;
        chk("t7_no_start", 32'(frame_active), 32'd0);
        do_tick();
        chk("t7_start", 32'(dout), 32'h701);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
